// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: Simon memory-game controller. It grows a random colour sequence, plays it back,
// checks the player's presses and requests an LCD print on WIN/LOSE. Optional macro: SIMON_TIMEOUT_EN.
module simon_game_ctrl #(
  parameter int NUM_BTN       = 4,
  parameter int MAX_LEN       = 32,
  parameter int SHOW_TICKS    = 50000000,
  parameter int GAP_TICKS     = 12500000,
  parameter int TIMEOUT_TICKS = 250000000,
  parameter int CW            = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NUM_BTN-1:0] i_pressed,
  input  logic [CW-1:0]      i_rnd,
  input  logic               i_lcd_available,
  output logic [CW-1:0]      o_color,
  output logic               o_led_en,
  output logic [7:0]         o_level,
  output logic               o_busy,
  output logic               o_win,
  output logic               o_lose,
  output logic               o_lcd_print
);

  localparam int MAXT = (SHOW_TICKS > GAP_TICKS) ?
                        ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS) :
                        ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
  localparam int TW = $clog2(MAXT + 1);
  localparam int IW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] SHOW_END = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_END  = TW'(GAP_TICKS - 1);
  localparam logic [7:0]    MAX_LVL  = MAX_LEN[7:0];
  localparam logic [CW:0]   NB       = NUM_BTN[CW:0];
`ifdef SIMON_TIMEOUT_EN
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXTEND,
    S_SHOW,
    S_GAP,
    S_WAIT_IN,
    S_ECHO,
    S_WIN,
    S_LOSE
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_idx;
  logic [7:0]    r_level;
  logic          r_pend;
  logic [CW-1:0] r_seq [MAX_LEN];

  logic [7:0]    w_idx_nx;
  logic [CW-1:0] w_rnd_fold;
  logic [CW-1:0] w_btn;
  logic [CW-1:0] w_exp;
  logic          w_one_press;

  function automatic logic [3:0] f_count(input logic [NUM_BTN-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] f_encode(input logic [NUM_BTN-1:0] v);
    logic [CW-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (v[i]) begin
        b = CW'(i);
      end
    end
    return b;
  endfunction

  // The LFSR value can exceed NUM_BTN-1 when NUM_BTN is not a power of two; fold it back.
  function automatic logic [CW-1:0] f_fold(input logic [CW-1:0] r);
    if ({1'b0, r} < NB) begin
      return r;
    end else begin
      return r - NB[CW-1:0];
    end
  endfunction

  assign w_idx_nx    = r_idx + 8'd1;
  assign w_rnd_fold  = f_fold(i_rnd);
  assign w_btn       = f_encode(i_pressed);
  assign w_one_press = (f_count(i_pressed) == 4'd1);
  assign w_exp       = r_seq[r_idx[IW-1:0]];
  assign o_level     = r_level;

  // Sequence storage, written once per round; left uncleared so start/reset need no clear pass.
  always_ff @(posedge i_clk) begin
    if (r_state == S_EXTEND && r_level < MAX_LVL) begin
      r_seq[r_level[IW-1:0]] <= w_rnd_fold;
    end
  end

  // Game FSM with registered outputs and the pending-print handshake.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_level     <= 8'd0;
      r_idx       <= 8'd0;
      r_timer     <= '0;
      r_pend      <= 1'b0;
      o_color     <= '0;
      o_led_en    <= 1'b0;
      o_win       <= 1'b0;
      o_lose      <= 1'b0;
      o_busy      <= 1'b0;
      o_lcd_print <= 1'b0;
    end else begin
      o_lcd_print <= r_pend & i_lcd_available;
      if (r_pend && i_lcd_available) begin
        r_pend <= 1'b0;
      end
      case (r_state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (i_start) begin
            r_state     <= S_EXTEND;
            r_level     <= 8'd0;
            r_idx       <= 8'd0;
            r_timer     <= '0;
            r_pend      <= 1'b0;
            o_lcd_print <= 1'b0;
            o_led_en    <= 1'b0;
            o_win       <= 1'b0;
            o_lose      <= 1'b0;
            o_busy      <= 1'b1;
          end
        end
        S_EXTEND: begin
          // The new colour is only readable next cycle, so bypass it when it is also seq[0].
          o_color  <= (r_level == 8'd0) ? w_rnd_fold : r_seq[0];
          o_led_en <= 1'b1;
          r_level  <= (r_level < MAX_LVL) ? r_level + 8'd1 : r_level;
          r_idx    <= 8'd0;
          r_timer  <= '0;
          r_state  <= S_SHOW;
        end
        S_SHOW: begin
          if (r_timer == SHOW_END) begin
            r_timer  <= '0;
            o_led_en <= 1'b0;
            r_state  <= S_GAP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_GAP: begin
          if (r_timer == GAP_END) begin
            r_timer <= '0;
            if (w_idx_nx < r_level) begin
              r_idx    <= w_idx_nx;
              o_color  <= r_seq[w_idx_nx[IW-1:0]];
              o_led_en <= 1'b1;
              r_state  <= S_SHOW;
            end else begin
              r_idx   <= 8'd0;
              r_state <= S_WAIT_IN;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_WAIT_IN: begin
          if (i_pressed != '0) begin
            if (w_one_press && w_btn == w_exp) begin
              o_color  <= w_btn;
              o_led_en <= 1'b1;
              r_timer  <= '0;
              r_state  <= S_ECHO;
            end else begin
              o_color  <= w_exp;
              o_led_en <= 1'b1;
              o_lose   <= 1'b1;
              o_busy   <= 1'b0;
              r_pend   <= 1'b1;
              r_state  <= S_LOSE;
            end
          end
`ifdef SIMON_TIMEOUT_EN
          else if (r_timer == TO_END) begin
            o_color  <= w_exp;
            o_led_en <= 1'b1;
            o_lose   <= 1'b1;
            o_busy   <= 1'b0;
            r_pend   <= 1'b1;
            r_state  <= S_LOSE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
`else
          else begin
            r_timer <= '0;
          end
`endif
        end
        S_ECHO: begin
          if (r_timer == GAP_END) begin
            r_timer  <= '0;
            o_led_en <= 1'b0;
            if (w_idx_nx < r_level) begin
              r_idx   <= w_idx_nx;
              r_state <= S_WAIT_IN;
            end else if (r_level == MAX_LVL) begin
              o_win   <= 1'b1;
              o_busy  <= 1'b0;
              r_pend  <= 1'b1;
              r_state <= S_WIN;
            end else begin
              r_state <= S_EXTEND;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// Randomized bench for simon_game_ctrl: plays whole games against a game-level model
// (colour queue plus the documented phase durations) and checks outputs cycle by cycle.
module tb_simon_game_ctrl;

  localparam int NB = 4;
  localparam int ML = 3;
  localparam int ST = 4;
  localparam int GT = 2;
  localparam int TT = 20;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] pressed;
  logic [1:0] rnd;
  logic       lcd_avail;
  logic [1:0] color;
  logic       led_en;
  logic [7:0] level;
  logic       busy;
  logic       win;
  logic       lose;
  logic       lcd_print;

  logic       start3;
  logic [2:0] pressed3;
  logic [1:0] rnd3;
  logic [1:0] color3;
  logic       led3;
  logic [7:0] level3;
  logic       busy3;
  logic       win3;
  logic       lose3;
  logic       print3;

  int n_vec;
  int n_err;
  int n_prints;
  int exp_prints;
  int m_seq[$];

  simon_game_ctrl #(
    .NUM_BTN(NB), .MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT), .TIMEOUT_TICKS(TT)
  ) u_dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_pressed(pressed), .i_rnd(rnd),
    .i_lcd_available(lcd_avail), .o_color(color), .o_led_en(led_en), .o_level(level),
    .o_busy(busy), .o_win(win), .o_lose(lose), .o_lcd_print(lcd_print)
  );

  simon_game_ctrl #(
    .NUM_BTN(3), .MAX_LEN(ML), .SHOW_TICKS(ST), .GAP_TICKS(GT), .TIMEOUT_TICKS(TT)
  ) u_dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start3), .i_pressed(pressed3), .i_rnd(rnd3),
    .i_lcd_available(lcd_avail), .o_color(color3), .o_led_en(led3), .o_level(level3),
    .o_busy(busy3), .o_win(win3), .o_lose(lose3), .o_lcd_print(print3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (lcd_print) n_prints++;
  endtask

  task automatic playback(input int r);
    for (int i = 0; i < r; i++) begin
      for (int k = 0; k < ST; k++) begin
        check_val("show_led", led_en, 1);
        check_val("show_color", color, m_seq[i]);
        check_val("show_level", level, r);
        pressed = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        tick();
        pressed = 4'd0;
      end
      for (int k = 0; k < GT; k++) begin
        check_val("gap_dark", led_en, 0);
        tick();
      end
    end
  endtask

  task automatic play_game(input bit allow_cancel);
    int wr;
    int wi;
    int kind;
    int idle;
    int k;
    int b;
    logic [3:0] v;
    bit lost;
    m_seq.delete();
    wr   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, ML);
    wi   = (wr > 0) ? $urandom_range(0, wr - 1) : -1;
    kind = $urandom_range(0, 1);
    lost = 1'b0;
    rnd  = 2'($urandom_range(0, 3));
    start = 1'b1;
    lcd_avail = 1'b1;
    tick();
    start = 1'b0;
    check_val("busy_after_start", busy, 1);
    check_val("level_cleared", level, 0);
    check_val("no_stale_print", n_prints, exp_prints);
    for (int r = 1; r <= ML && !lost; r++) begin
      m_seq.push_back(int'(rnd) % NB);
      tick();
      playback(r);
      for (int i = 0; i < r && !lost; i++) begin
        idle = $urandom_range(0, 5);
        repeat (idle) begin
          check_val("wait_dark", led_en, 0);
          tick();
        end
        check_val("wait_busy", busy, 1);
        check_val("wait_no_lose", lose, 0);
        if (r == wr && i == wi) begin
          lcd_avail = 1'b0;
          if (kind == 0) begin
            b = (m_seq[i] + $urandom_range(1, NB - 1)) % NB;
            pressed = 4'(1 << b);
          end else begin
            v = 4'($urandom_range(3, 15));
            while ($countones(v) < 2) v = 4'($urandom_range(3, 15));
            pressed = v;
          end
          tick();
          pressed = 4'd0;
          lost = 1'b1;
          check_val("lose_flag", lose, 1);
          check_val("lose_led", led_en, 1);
          check_val("lose_color", color, m_seq[i]);
          check_val("lose_busy", busy, 0);
          check_val("lose_win", win, 0);
          check_val("lose_level", level, r);
        end else begin
          pressed = 4'(1 << m_seq[i]);
          rnd = 2'($urandom_range(0, 3));
          if (r == ML && i == r - 1) lcd_avail = 1'b0;
          tick();
          pressed = 4'd0;
          for (int e = 0; e < GT; e++) begin
            check_val("echo_led", led_en, 1);
            check_val("echo_color", color, m_seq[i]);
            tick();
          end
        end
      end
    end
    if (!lost) begin
      check_val("win_flag", win, 1);
      check_val("win_lose", lose, 0);
      check_val("win_led", led_en, 0);
      check_val("win_busy", busy, 0);
      check_val("win_level", level, ML);
    end
    check_val("print_not_early", lcd_print, 0);
    k = $urandom_range(0, 5);
    repeat (k) begin
      tick();
      check_val("print_held_off", lcd_print, 0);
    end
    // Leaving the request pending lets the next game's start cancel it.
    if (!(allow_cancel && $urandom_range(0, 3) == 0)) begin
      lcd_avail = 1'b1;
      tick();
      check_val("print_pulse", lcd_print, 1);
      check_val("outcome_held", lost ? lose : win, 1);
      tick();
      check_val("print_once", lcd_print, 0);
      exp_prints++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_prints = 0;
    exp_prints = 0;
    reset = 1'b1;
    start = 1'b0;
    pressed = 4'd0;
    rnd = 2'd0;
    lcd_avail = 1'b1;
    start3 = 1'b0;
    pressed3 = 3'd0;
    rnd3 = 2'd0;
    repeat (3) tick();
    check_val("rst_color", color, 0);
    check_val("rst_led", led_en, 0);
    check_val("rst_level", level, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_win", win, 0);
    check_val("rst_lose", lose, 0);
    check_val("rst_print", lcd_print, 0);
    reset = 1'b0;
    tick();
    check_val("idle_busy", busy, 0);

    for (int g = 0; g < 30; g++) play_game(g < 29);

    // Idle player in WAIT_IN.
    m_seq.delete();
    rnd = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_seq.push_back(1);
    tick();
    playback(1);
    check_val("wait_entry", lose, 0);
`ifdef SIMON_TIMEOUT_EN
    repeat (TT - 1) tick();
    check_val("timeout_not_yet", lose, 0);
    tick();
    check_val("timeout_lose", lose, 1);
    check_val("timeout_led", led_en, 1);
    check_val("timeout_color", color, 1);
    check_val("timeout_busy", busy, 0);
    tick();
    check_val("timeout_print", lcd_print, 1);
    exp_prints++;
    tick();
`else
    repeat (100) tick();
    check_val("no_timeout_lose", lose, 0);
    check_val("no_timeout_busy", busy, 1);
    check_val("no_timeout_led", led_en, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_level", level, 0);
    repeat (5) tick();
`endif

    // Reset in the middle of playback.
    rnd = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_val("mid_show_led", led_en, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mid_rst_color", color, 0);
    check_val("mid_rst_led", led_en, 0);
    check_val("mid_rst_level", level, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_win", win, 0);
    check_val("mid_rst_lose", lose, 0);
    check_val("mid_rst_print", lcd_print, 0);
    repeat (10) tick();
    check_val("post_rst_idle", busy, 0);

    // Three-button instance: rnd=3 must fold to colour 0.
    rnd3 = 2'd3;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    check_val("fold_color", color3, 0);
    check_val("fold_led", led3, 1);
    check_val("fold_level", level3, 1);
    check_val("fold_busy", busy3, 1);
    repeat (ST + GT) tick();
    pressed3 = 3'b001;
    tick();
    pressed3 = 3'd0;
    check_val("fold_echo_led", led3, 1);
    check_val("fold_echo_color", color3, 0);
    check_val("fold_no_lose", lose3, 0);
    check_val("fold_no_win", win3, 0);
    check_val("fold_no_print", print3, 0);

    check_val("print_total", n_prints, exp_prints);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simon_game_ctrl.md
SIMON_GAME_CTRL -- requirements
Module: simon_game_ctrl

Interface
REQ-001 Parameter NUM_BTN, default 4: number of buttons/colours, legal range 2..8.
REQ-002 Parameter MAX_LEN, default 32: maximum sequence length, legal range 2..255.
REQ-003 Parameter SHOW_TICKS, default 50000000: clocks each colour is lit during playback.
REQ-004 Parameter GAP_TICKS, default 12500000: dark clocks after each playback colour, and echo-on clocks after each correct press.
REQ-005 Parameter TIMEOUT_TICKS, default 250000000: clocks allowed per press (used only under SIMON_TIMEOUT_EN).
REQ-006 Derived CW = clog2(NUM_BTN), minimum 1.
REQ-007 clk  in  1  single clock; all logic on posedge clk.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse; begins a new game.
REQ-010 pressed  in  NUM_BTN  debounced one-cycle press pulses; bit i = button i.
REQ-011 rnd  in  CW  pseudo-random value from the LFSR, sampled in EXTEND.
REQ-012 lcd_available  in  1  LCD string driver idle.
REQ-013 color  out  CW  colour index to the LED controller.
REQ-014 led_en  out  1  LED lit when high.
REQ-015 level  out  8  current sequence length.
REQ-016 busy  out  1  high in every state except IDLE, WIN and LOSE.
REQ-017 win, lose  out  1 each  held high while in WIN or LOSE respectively.
REQ-018 lcd_print  out  1  one-cycle print request to the LCD driver.

Function
REQ-019 States: IDLE, EXTEND, SHOW, GAP, WAIT_IN, ECHO, WIN, LOSE; one timer counter and one index counter idx.
REQ-020 start in IDLE, WIN or LOSE: level<=0, idx<=0, go to EXTEND next cycle; start in any other state is ignored.
REQ-021 EXTEND (1 cycle): seq[level] <= rnd if rnd<NUM_BTN, else rnd-NUM_BTN; level<=level+1; idx<=0; go to SHOW.
REQ-022 SHOW: color=seq[idx], led_en=1 for exactly SHOW_TICKS cycles, then GAP.
REQ-023 GAP: led_en=0 for GAP_TICKS cycles; then idx<=idx+1 and SHOW if idx+1<level, else idx<=0 and WAIT_IN.
REQ-024 pressed is ignored in every state except WAIT_IN.
REQ-025 WAIT_IN, exactly one pressed bit b set and b==seq[idx]: color<=b, enter ECHO.
REQ-026 WAIT_IN, exactly one bit set and b!=seq[idx], or two or more bits set in the same cycle: enter LOSE.
REQ-027 ECHO: led_en=1, color=b for GAP_TICKS cycles; then idx<=idx+1 and WAIT_IN if idx+1<level; else WIN if level==MAX_LEN; else EXTEND.
REQ-028 LOSE: color=seq[idx] (the expected colour), led_en=1 continuously; WIN: led_en=0.
REQ-029 On entry to WIN or LOSE a print request becomes pending; lcd_print pulses for one cycle on the first cycle in which the request is pending and lcd_available=1; then the request clears. A start that arrives while the request is pending cancels it.
REQ-030 level saturates at MAX_LEN; seq storage is MAX_LEN x CW and is not cleared by start or reset.
REQ-031 All outputs are registered; the first playback colour is lit 2 cycles after the start pulse.

Reset
REQ-032 reset has priority over all inputs: state<=IDLE, level<=0, idx<=0, timer<=0, color<=0, led_en<=0, win<=0, lose<=0, busy<=0, lcd_print<=0, pending print cleared.
REQ-033 reset asserted mid-playback or mid-input aborts the game with no lcd_print pulse.

Configuration
REQ-034 Macro SIMON_TIMEOUT_EN defined: in WAIT_IN the timer restarts on entry; TIMEOUT_TICKS cycles with no pressed bit set enter LOSE.
REQ-035 Macro SIMON_TIMEOUT_EN undefined: WAIT_IN waits indefinitely; TIMEOUT_TICKS is unused.

Verification (SHOW_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20, MAX_LEN=3, NUM_BTN=4 unless noted)
REQ-036 Reset, then start with rnd=2 -> led_en=1 and color=2 for 4 cycles, then dark for 2 cycles; WAIT_IN reached; level=1.
REQ-037 Correct presses with rnd values 2, 1, 3 over three rounds -> WIN after the third round; win=1; level=3; exactly one lcd_print pulse.
REQ-038 In WAIT_IN with seq[0]=2, press button 0 -> LOSE; led_en=1 with color=2; lose=1; with lcd_available=0 for 5 cycles, lcd_print is delayed until lcd_available rises.
REQ-039 In WAIT_IN, pressed=4'b0011 in a single cycle -> LOSE; pressed pulses during SHOW -> ignored.
REQ-040 NUM_BTN=3, rnd=3 -> stored colour is 0; with SIMON_TIMEOUT_EN, 20 idle cycles in WAIT_IN -> LOSE; without the macro -> still WAIT_IN after 100 cycles.
REQ-041 reset asserted during SHOW -> all outputs are at their reset values on the next cycle, and no lcd_print pulse occurs.
